pipe_sequencer: RTL and testbench

Three-stage pipeline controller (fetch / decode / execute) for the 4-bit core. It owns the program counter, the stage valid bits, the carry flag and branch resolution. It detects register read-after-write hazards between the decode and execute stages and either stalls or forwards. It sits between instruction memory and the decode/execute datapath, and gates every register write and output strobe the datapath performs.

---
 rtl/pipe_sequencer.sv | 121 ++++++++++++
 tb/tb_pipe_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Fetch/decode/execute pipeline controller for the 4-bit core: PC, stage valids, carry flag,
// branch resolution and RAW hazard handling. Define PIPE_FWD_EN to forward instead of stalling.
module pipe_sequencer #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] id_inst,
    output logic       id_valid,
    output logic [7:0] ex_inst,
    output logic       ex_valid,
    input  logic       ex_carry,
    output logic       ex_wr,
    output logic       ex_dst,
    output logic       ex_out_en,
    output logic       jump_taken,
    output logic       stall,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       carry_flag
);

    localparam int unsigned PC_W = 4;

    logic [PC_W-1:0] pc;
    logic id_rd_a, id_rd_b;
    logic ex_wr_dec, ex_dst_dec, ex_out_dec, ex_add, ex_clr, ex_jmp, ex_jnc;
    logic ex_wr_raw, haz_a, haz_b;

    // Operand reads of the instruction sitting in decode
    always_comb begin
        id_rd_a = 1'b0;
        id_rd_b = 1'b0;
        case (id_inst[7:4])
            4'b0000, 4'b0100:         id_rd_a = 1'b1;
            4'b0101, 4'b0001, 4'b1001: id_rd_b = 1'b1;
            default: ;
        endcase
    end

    // Side effects of the instruction sitting in execute
    always_comb begin
        ex_wr_dec  = 1'b0;
        ex_dst_dec = 1'b0;
        ex_out_dec = 1'b0;
        ex_add     = 1'b0;
        ex_clr     = 1'b0;
        ex_jmp     = 1'b0;
        ex_jnc     = 1'b0;
        case (ex_inst[7:4])
            4'b0000: begin ex_wr_dec = 1'b1; ex_add = 1'b1; end
            4'b0101: begin ex_wr_dec = 1'b1; ex_dst_dec = 1'b1; ex_add = 1'b1; end
            4'b0011, 4'b0001, 4'b0010: begin ex_wr_dec = 1'b1; ex_clr = 1'b1; end
            4'b0111, 4'b0100, 4'b0110: begin
                ex_wr_dec  = 1'b1;
                ex_dst_dec = 1'b1;
                ex_clr     = 1'b1;
            end
            4'b1001, 4'b1011: ex_out_dec = 1'b1;
            4'b1111: ex_jmp = 1'b1;
            4'b1110: ex_jnc = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr  = pc;
    assign ex_wr_raw  = ex_valid & ex_wr_dec;
    assign ex_wr      = ex_wr_raw & run;
    assign ex_out_en  = ex_valid & ex_out_dec & run;
    assign ex_dst     = ex_dst_dec;
    // JNC looks at the flag as it stood before this cycle's EX update
    assign jump_taken = ex_valid & (ex_jmp | (ex_jnc & ~carry_flag));
    assign haz_a      = id_valid & ex_wr_raw & ~ex_dst_dec & id_rd_a;
    assign haz_b      = id_valid & ex_wr_raw &  ex_dst_dec & id_rd_b;

`ifdef PIPE_FWD_EN
    assign stall = 1'b0;
    assign fwd_a = haz_a;
    assign fwd_b = haz_b;
`else
    assign stall = (haz_a | haz_b) & ~jump_taken;
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    // Pipeline advance: flush beats stall beats normal flow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            id_inst    <= 8'h00;
            id_valid   <= 1'b0;
            ex_inst    <= 8'h00;
            ex_valid   <= 1'b0;
            carry_flag <= 1'b0;
        end else if (run) begin
            if (ex_valid) begin
                if (ex_add)
                    carry_flag <= ex_carry;
                else if (ex_clr)
                    carry_flag <= 1'b0;
            end
            if (jump_taken) begin
                pc       <= ex_inst[3:0];
                id_valid <= 1'b0;
                ex_valid <= 1'b0;
            end else if (stall) begin
                ex_valid <= 1'b0;
            end else begin
                ex_inst  <= id_inst;
                ex_valid <= id_valid;
                id_inst  <= imem_data;
                id_valid <= 1'b1;
                pc       <= pc + PC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: directed programs push expected EX events,
// a negedge monitor pops and compares every non-NOP instruction executed with run=1.
module tb_pipe_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] id_inst, ex_inst;
    logic       id_valid, ex_valid, ex_carry;
    logic       ex_wr, ex_dst, ex_out_en, jump_taken, stall, fwd_a, fwd_b, carry_flag;

    logic [7:0] mem [16];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    pipe_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .id_inst(id_inst), .id_valid(id_valid),
        .ex_inst(ex_inst), .ex_valid(ex_valid),
        .ex_carry(ex_carry), .ex_wr(ex_wr), .ex_dst(ex_dst), .ex_out_en(ex_out_en),
        .jump_taken(jump_taken), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .carry_flag(carry_flag)
    );

    typedef struct packed {
        logic [7:0] inst;
        logic       wr;
        logic       dst;
        logic       out;
        logic       jt;
        logic       cf;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input logic [7:0] inst, input logic wr, input logic dst,
                             input logic out, input logic jt, input logic cf);
        ev_t e;
        e.inst = inst; e.wr = wr; e.dst = dst; e.out = out; e.jt = jt; e.cf = cf;
        exp_q.push_back(e);
    endtask

    function automatic logic is_nop(input logic [7:0] inst);
        logic [3:0] op;
        op = inst[7:4];
        return (op == 4'b1000) || (op == 4'b1010) || (op == 4'b1100) || (op == 4'b1101);
    endfunction

    // Monitor: every executed non-NOP instruction must match the next expected event
    always @(negedge clk) begin
        if (!rst && run && ex_valid && !is_nop(ex_inst)) begin
            ev_t act, e;
            act = {ex_inst, ex_wr, ex_dst, ex_out_en, jump_taken, carry_flag};
            if (exp_q.size() == 0) begin
                check("unexpected_ex_event", 32'(act), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("ex_event", 32'(act), 32'(e));
            end
        end
    end

    task automatic load_nops();
        for (int i = 0; i < 16; i++) mem[i] = 8'h80;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic end_scenario(input string nm);
        repeat (2) @(negedge clk);
        check({nm, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int i;
        ex_carry = 1'b0;
        load_nops();
        #2;
        check("rst_pc",      32'(imem_addr),  32'h0);
        check("rst_id_v",    32'(id_valid),   32'h0);
        check("rst_ex_v",    32'(ex_valid),   32'h0);
        check("rst_carry",   32'(carry_flag), 32'h0);
        check("rst_strobes", 32'({ex_wr, ex_out_en, jump_taken, stall}), 32'h0);

        // 1: MOV A,3 ; ADD A,1 (hazard) ; OUT B ; MOV B,5
        do_reset();
        load_nops();
        mem[0] = 8'h33; mem[1] = 8'h01; mem[2] = 8'h90; mem[3] = 8'h75;
        ex_carry = 1'b1;
        expect_ev(8'h33, 1, 0, 0, 0, 0);
        expect_ev(8'h01, 1, 0, 0, 0, 0);
        expect_ev(8'h90, 0, 0, 1, 0, 1);
        expect_ev(8'h75, 1, 1, 0, 0, 1);
        run = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("s1_ex_first", 32'({ex_valid, ex_inst}), 32'h133);
`ifdef PIPE_FWD_EN
        check("s1_stall", 32'(stall), 32'h0);
        check("s1_fwd_a", 32'(fwd_a), 32'h1);
        @(posedge clk); #1;
        check("s1_ex_next", 32'({ex_valid, ex_inst}), 32'h101);
`else
        check("s1_stall", 32'(stall), 32'h1);
        check("s1_fwd_a", 32'(fwd_a), 32'h0);
        @(posedge clk); #1;
        check("s1_bubble", 32'({ex_valid, id_inst, stall}), 32'h002);
`endif
        repeat (5) @(posedge clk);
        #1 run = 1'b0;
        end_scenario("s1");

        // 2: MOV A,1 ; ADD A,15 carry=1 ; JNC 8 not taken ; OUT 3
        do_reset();
        load_nops();
        mem[0] = 8'h31; mem[1] = 8'h0F; mem[2] = 8'hE8; mem[3] = 8'hB3; mem[8] = 8'hB9;
        ex_carry = 1'b1;
        expect_ev(8'h31, 1, 0, 0, 0, 0);
        expect_ev(8'h0F, 1, 0, 0, 0, 0);
        expect_ev(8'hE8, 0, 0, 0, 0, 1);
        expect_ev(8'hB3, 0, 0, 1, 0, 1);
        run = 1'b1;
        repeat (8) @(posedge clk);
        #1 run = 1'b0;
        check("s2_carry", 32'(carry_flag), 32'h1);
        end_scenario("s2");

        // 3: same program with carry=0 -> JNC 8 taken, OUT 3 flushed
        do_reset();
        ex_carry = 1'b0;
        expect_ev(8'h31, 1, 0, 0, 0, 0);
        expect_ev(8'h0F, 1, 0, 0, 0, 0);
        expect_ev(8'hE8, 0, 0, 0, 1, 0);
        expect_ev(8'hB9, 0, 0, 1, 0, 0);
        run = 1'b1;
        @(negedge clk);
        for (i = 0; i < 20 && !jump_taken; i++) @(negedge clk);
        check("s3_jump_seen", 32'(jump_taken), 32'h1);
        @(posedge clk); #1;
        check("s3_flush", 32'({imem_addr, id_valid, ex_valid}), 32'({4'h8, 2'b00}));
        @(posedge clk); #1;
        check("s3_target_id", 32'({id_valid, id_inst, ex_valid}), 32'({1'b1, 8'hB9, 1'b0}));
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        check("s3_carry", 32'(carry_flag), 32'h0);
        end_scenario("s3");

        // 4: JMP 15 at 0, JMP 0 at 15 -> PC wraps 15 -> 0
        do_reset();
        load_nops();
        mem[0] = 8'hFF; mem[15] = 8'hF0;
        expect_ev(8'hFF, 0, 0, 0, 1, 0);
        expect_ev(8'hF0, 0, 0, 0, 1, 0);
        run = 1'b1;
        @(negedge clk);
        for (i = 0; i < 20 && !(id_valid && id_inst == 8'hF0); i++) @(negedge clk);
        check("s4_wrap_pc", 32'({id_valid, id_inst, imem_addr}), 32'({1'b1, 8'hF0, 4'h0}));
        for (i = 0; i < 20 && !(jump_taken && ex_inst == 8'hF0); i++) @(negedge clk);
        check("s4_jmp0_seen", 32'(jump_taken), 32'h1);
        @(posedge clk);
        #1 run = 1'b0;
        check("s4_flush", 32'({imem_addr, id_valid, ex_valid}), 32'h0);
        end_scenario("s4");

        // 5: run held low 3 cycles mid-program
        do_reset();
        load_nops();
        mem[0] = 8'h32; mem[1] = 8'h74; mem[2] = 8'hB5;
        mem[3] = 8'h20; mem[4] = 8'h60; mem[5] = 8'hB6;
        expect_ev(8'h32, 1, 0, 0, 0, 0);
        expect_ev(8'h74, 1, 1, 0, 0, 0);
        expect_ev(8'hB5, 0, 0, 1, 0, 0);
        expect_ev(8'h20, 1, 0, 0, 0, 0);
        expect_ev(8'h60, 1, 1, 0, 0, 0);
        expect_ev(8'hB6, 0, 0, 1, 0, 0);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("s5_frozen", 32'({imem_addr, ex_valid, ex_inst, id_inst}),
                  32'({4'h3, 1'b1, 8'h74, 8'hB5}));
            check("s5_no_wr", 32'({ex_wr, ex_out_en}), 32'h0);
        end
        run = 1'b1;
        repeat (5) @(posedge clk);
        #1 run = 1'b0;
        end_scenario("s5");

        // 6: reset pulsed while JMP 9 sits in EX
        do_reset();
        load_nops();
        mem[0] = 8'h71; mem[1] = 8'hF9; mem[9] = 8'hB1;
        expect_ev(8'h71, 1, 1, 0, 0, 0);
        expect_ev(8'hF9, 0, 0, 0, 1, 0);
        run = 1'b1;
        @(negedge clk);
        for (i = 0; i < 20 && !jump_taken; i++) @(negedge clk);
        check("s6_jump_seen", 32'(jump_taken), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("s6_rst_async", 32'({imem_addr, id_valid, ex_valid, jump_taken}), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("s6_restart", 32'({imem_addr, id_valid, id_inst}), 32'({4'h1, 1'b1, 8'h71}));
        run = 1'b0;
        end_scenario("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
